// File: rtl/memoria_principal.sv
// Main-memory model behind the data cache. It answers aligned 128-bit refill
// reads after a fixed latency. Write-through stores go into a posted write
// buffer (FIFO), which drains into the doubleword array at a fixed pace.
// A read is answered only once every write buffered ahead of it has committed.
module memoria_principal #(
  parameter int ADDR_DW_LOG2  = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int WBUF_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  mem_address,
  input  logic [63:0]  mem_write_data,
  input  logic         mem_read_out,
  input  logic         mem_write_out,
  output logic [127:0] mem_block_read_data,
  output logic         mem_ready,
  output logic         wbuf_full,
  output logic         wr_overflow,
  output logic         busy
);

  localparam int DW_CNT = 1 << ADDR_DW_LOG2;
  localparam int BW     = ADDR_DW_LOG2 - 1;
  localparam int PW     = $clog2(WBUF_DEPTH);
  localparam int CW     = PW + 1;
  localparam int RW     = (READ_LATENCY  > 1) ? $clog2(READ_LATENCY)  : 1;
  localparam int WW     = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);
  localparam logic [RW-1:0] RD_LAST  = RW'(READ_LATENCY - 1);
  localparam logic [WW-1:0] WR_LAST  = WW'(WRITE_LATENCY - 1);

  typedef struct packed {
    logic [ADDR_DW_LOG2-1:0] idx;
    logic [63:0]             data;
  } wentry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    RD_HOLD = 2'd3
  } state_t;

  // Storage. Reset does not clear it.
  logic [63:0] r_mem  [DW_CNT];
  wentry_t     r_fifo [WBUF_DEPTH];

  // Write buffer control
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_wcnt;

  // Read side
  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_blk;
  logic [RW-1:0] r_rcnt;
  logic          w_accept;
  logic          w_launch;

  logic [ADDR_DW_LOG2-1:0] w_dw_idx;
  logic [BW-1:0]           w_blk_idx;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  wentry_t                 w_head;
  logic                    w_unused_addr;

  // Addresses wrap: anything above the array size is simply discarded.
  assign w_dw_idx      = mem_address[ADDR_DW_LOG2+2:3];
  assign w_blk_idx     = mem_address[ADDR_DW_LOG2+2:4];
  assign w_unused_addr = ^{mem_address[31:ADDR_DW_LOG2+3], mem_address[2:0]};

  // Fullness is taken before the edge. A store that arrives while the buffer
  // is full is dropped, even if the head is popping on that same edge.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = mem_write_out && !w_full;
  assign w_pop   = !w_empty && (r_wcnt == WR_LAST);
  assign w_head  = r_fifo[r_rd_ptr];

  assign wbuf_full = w_full;
  assign busy      = (r_state != IDLE) || !w_empty;

  // Buffer pointers, occupancy, drain pacing and the sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wcnt      <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // The pacing counter runs only while an entry is waiting. An entry
      // pushed into an empty buffer therefore commits WRITE_LATENCY edges later.
      if (w_empty || w_pop) r_wcnt <= '0;
      else                  r_wcnt <= r_wcnt + WW'(1);
      if (mem_write_out && w_full) wr_overflow <= 1'b1;
    end
  end

  // Write-buffer entry capture
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{idx: w_dw_idx, data: mem_write_data};
  end

  // Commit of the buffer head into the array
  always_ff @(posedge clk) begin
    if (w_pop) r_mem[w_head.idx] <= w_head.data;
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Read FSM next state. A response waits for the latency to expire and for
  // the write buffer to be empty with nothing entering it. This keeps the
  // array from being read and written on the same edge.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_launch = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read_out) begin
          w_accept = 1'b1;
          w_next   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if ((r_rcnt == RD_LAST) && w_empty && !w_push) begin
          w_launch = 1'b1;
          w_next   = RD_RESP;
        end
      end
      // The cache keeps its request up while it sees mem_ready. These two
      // states let that stale level pass without being taken as a new read.
      RD_RESP: w_next = RD_HOLD;
      RD_HOLD: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read datapath: latch the block, count the latency, register the response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blk               <= '0;
      r_rcnt              <= '0;
      mem_ready           <= 1'b0;
      mem_block_read_data <= '0;
    end else begin
      if (w_accept) begin
        r_blk  <= w_blk_idx;
        r_rcnt <= '0;
      end else if ((r_state == RD_WAIT) && (r_rcnt != RD_LAST)) begin
        r_rcnt <= r_rcnt + RW'(1);
      end
      mem_ready <= w_launch;
      if (w_launch)
        mem_block_read_data <= {r_mem[{r_blk, 1'b1}], r_mem[{r_blk, 1'b0}]};
    end
  end

endmodule

// File: tb/tb_memoria_principal.sv
// Directed bench for memoria_principal, using the default parameters
// (READ_LATENCY=4, WRITE_LATENCY=2, WBUF_DEPTH=4).
module tb_memoria_principal;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  mem_address;
  logic [63:0]  mem_write_data;
  logic         mem_read_out;
  logic         mem_write_out;
  logic [127:0] mem_block_read_data;
  logic         mem_ready;
  logic         wbuf_full;
  logic         wr_overflow;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [63:0] A  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] C  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] P0 = 64'h5A5A_5A5A_0000_0001;
  localparam logic [63:0] P1 = 64'hA5A5_A5A5_0000_0002;

  memoria_principal #(
    .ADDR_DW_LOG2 (10),
    .READ_LATENCY (4),
    .WRITE_LATENCY(2),
    .WBUF_DEPTH   (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_address        (mem_address),
    .mem_write_data     (mem_write_data),
    .mem_read_out       (mem_read_out),
    .mem_write_out      (mem_write_out),
    .mem_block_read_data(mem_block_read_data),
    .mem_ready          (mem_ready),
    .wbuf_full          (wbuf_full),
    .wr_overflow        (wr_overflow),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One active edge, then observe at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [63:0] d);
    mem_address    = a;
    mem_write_data = d;
    mem_write_out  = 1'b1;
    step();
    mem_write_out  = 1'b0;
  endtask

  // The first edge is the acceptance edge R. lat is the number of further
  // edges until mem_ready is seen. mem_read_out is left high.
  task automatic rd(input logic [31:0] a, input bit wr, input logic [63:0] wd, output int lat);
    mem_address  = a;
    mem_read_out = 1'b1;
    if (wr) begin
      mem_write_data = wd;
      mem_write_out  = 1'b1;
    end
    step();
    mem_write_out = 1'b0;
    lat = 0;
    while (mem_ready !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_rd();
    mem_read_out = 1'b0;
    step();
    step();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 128'(busy), 128'(0));
  endtask

  task automatic quiet(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      step();
      if (mem_ready === 1'b1) pulses++;
    end
  endtask

  initial begin
    int lat;
    int p;
    reset          = 1'b1;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read_out   = 1'b0;
    mem_write_out  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_ready", 128'(mem_ready),   128'(0));
    chk("rst_data",  mem_block_read_data, 128'(0));
    chk("rst_full",  128'(wbuf_full),   128'(0));
    chk("rst_ovf",   128'(wr_overflow), 128'(0));
    chk("rst_busy",  128'(busy),        128'(0));
    reset = 1'b0;
    step();

    // Two stores, then a read of the same block. The read waits for both commits.
    st(32'h40, A);
    st(32'h48, B);
    rd(32'h40, 1'b0, 64'h0, lat);
    chk("wr_rd_lat",  128'(lat), 128'(4));
    chk("wr_rd_data", mem_block_read_data, {B, A});
    mem_read_out = 1'b0;
    quiet(6, p);
    chk("wr_rd_one_pulse", 128'(p), 128'(0));

    // Pure read latency with an empty buffer
    rd(32'h100, 1'b0, 64'h0, lat);
    chk("lat_ready_R4", 128'(lat), 128'(4));
    mem_read_out = 1'b0;
    step();
    chk("lat_ready_low_R5", 128'(mem_ready), 128'(0));
    chk("lat_busy_R5",      128'(busy),      128'(1));
    step();
    step();
    chk("lat_busy_low_R7",  128'(busy),      128'(0));

    // Held stale request, then a fresh read on the third edge after mem_ready
    st(32'h200, C);
    st(32'h208, D);
    drain("held_drain");
    rd(32'h100, 1'b0, 64'h0, lat);
    chk("held_lat1", 128'(lat), 128'(4));
    step();
    chk("held_ignore1", 128'(mem_ready), 128'(0));
    step();
    chk("held_ignore2", 128'(mem_ready), 128'(0));
    rd(32'h200, 1'b0, 64'h0, lat);
    chk("held_lat2",  128'(lat), 128'(4));
    chk("held_data2", mem_block_read_data, {D, C});
    finish_rd();

    // A store and a read on the same edge: the read returns the new data
    rd(32'h10, 1'b1, 64'h5, lat);
    chk("order_lat",  128'(lat), 128'(4));
    chk("order_data", 128'(mem_block_read_data[63:0]), 128'(64'h5));
    finish_rd();

    // Overflow. With a pop every other edge, the buffer is full after the
    // sixth consecutive store, and the seventh store is dropped.
    st(32'h330, P0);
    st(32'h338, P1);
    drain("ovf_predrain");
    for (int i = 0; i < 7; i++) begin
      st(32'h300 + 32'(i * 8), 64'hD000_0000_0000_0000 | 64'(i));
      if (i == 4) chk("ovf_full_s5", 128'(wbuf_full), 128'(0));
      if (i == 5) begin
        chk("ovf_full_s6", 128'(wbuf_full),   128'(1));
        chk("ovf_flag_s6", 128'(wr_overflow), 128'(0));
      end
      if (i == 6) begin
        chk("ovf_flag_s7", 128'(wr_overflow), 128'(1));
        chk("ovf_full_s7", 128'(wbuf_full),   128'(0));
      end
    end
    drain("ovf_drain");
    rd(32'h300, 1'b0, 64'h0, lat);
    chk("ovf_rb0", mem_block_read_data, {64'hD000_0000_0000_0001, 64'hD000_0000_0000_0000});
    finish_rd();
    rd(32'h310, 1'b0, 64'h0, lat);
    chk("ovf_rb1", mem_block_read_data, {64'hD000_0000_0000_0003, 64'hD000_0000_0000_0002});
    finish_rd();
    rd(32'h320, 1'b0, 64'h0, lat);
    chk("ovf_rb2", mem_block_read_data, {64'hD000_0000_0000_0005, 64'hD000_0000_0000_0004});
    finish_rd();
    rd(32'h330, 1'b0, 64'h0, lat);
    chk("ovf_rb3_dropped", mem_block_read_data, {P1, P0});
    finish_rd();
    chk("ovf_sticky", 128'(wr_overflow), 128'(1));

    // Reset while a read waits behind a full write buffer
    mem_read_out = 1'b1;
    for (int i = 0; i < 6; i++) st(32'h400 + 32'(i * 8), 64'hC0DE_0000_0000_0000 | 64'(i));
    chk("mid_full",  128'(wbuf_full), 128'(1));
    chk("mid_busy",  128'(busy),      128'(1));
    chk("mid_ready", 128'(mem_ready), 128'(0));
    mem_read_out = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 128'(mem_ready),   128'(0));
    chk("mid_rst_busy",  128'(busy),        128'(0));
    chk("mid_rst_full",  128'(wbuf_full),   128'(0));
    chk("mid_rst_data",  mem_block_read_data, 128'(0));
    chk("mid_rst_ovf",   128'(wr_overflow), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    quiet(10, p);
    chk("post_rst_no_pulse", 128'(p),    128'(0));
    chk("post_rst_idle",     128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
